// File: rtl/scpad_xbar_arbiter_pkg.sv
// Shared types and constants for the scratchpad crossbar arbiter.
// Requester indices name the four scratchpad direction FSMs.
package scpad_xbar_arbiter_pkg;

    localparam int SCPAD_NUM_REQ = 4;
    localparam int SCPAD_ADDR_W  = 12;
    localparam int SCPAD_LEN_W   = 5;

    localparam int REQ_FE_RD = 0;
    localparam int REQ_FE_WR = 1;
    localparam int REQ_BE_RD = 2;
    localparam int REQ_BE_WR = 3;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_BURST     = 2'd1,
        ARB_WAIT_RESP = 2'd2,
        ARB_DONE      = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                    write;
        logic [SCPAD_ADDR_W-1:0] addr;
        logic [SCPAD_LEN_W-1:0]  len;
    } scpad_burst_desc_t;

endpackage

// File: rtl/scpad_rr_picker.sv
// Combinational round-robin picker: first asserted request
// found scanning upward from ptr, wrapping modulo NUM_REQ.
module scpad_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any_valid
);

    function automatic logic [IDW-1:0] wrap_idx(
        input logic [IDW-1:0] p,
        input int             k
    );
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    logic [IDW-1:0] cand;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_idx(ptr, k);
            if (!any_valid && req[cand]) begin
                any_valid   = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/scpad_xbar_arbiter.sv
// Round-robin owner of the scratchpad crossbar/SRAM issue port:
// accepts one burst, issues its beats, counts responses, pulses done.
module scpad_xbar_arbiter
    import scpad_xbar_arbiter_pkg::*;
#(
    parameter int NUM_REQ = SCPAD_NUM_REQ,
    parameter int ADDR_W  = SCPAD_ADDR_W,
    parameter int LEN_W   = SCPAD_LEN_W,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    grant_valid,
    output logic [IDW-1:0]          grant_id,
    output logic                    xbar_valid,
    input  logic                    xbar_ready,
    output logic                    xbar_write,
    output logic [ADDR_W-1:0]       xbar_addr,
    output logic                    xbar_last,
    input  logic                    sram_resp_valid,
    output logic [NUM_REQ-1:0]      done,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int CW = LEN_W + 1;
    typedef logic [CW-1:0] cnt_t;

    arb_state_t        state;
    arb_state_t        state_n;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    owner;
    scpad_burst_desc_t desc_q;
    scpad_burst_desc_t desc_in;
    cnt_t              beat_cnt;
    cnt_t              resp_cnt;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

    scpad_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    always_comb begin
        desc_in.write = req_write[pick_idx];
        desc_in.addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
        desc_in.len   = req_len[pick_idx*LEN_W +: LEN_W];
    end

    cnt_t beats;
    cnt_t issued;
    cnt_t resp_nxt;
    logic hs;
    logic in_xfer;
    logic resp_ok;
    logic accept;
    logic last_beat;

    assign beats     = cnt_t'(desc_q.len) + cnt_t'(1);
    assign last_beat = (beat_cnt == cnt_t'(desc_q.len));
    assign hs        = (state == ARB_BURST) && xbar_ready;
    assign in_xfer   = (state == ARB_BURST) || (state == ARB_WAIT_RESP);
    // A response may land in the same cycle as the beat it answers.
    assign issued    = beat_cnt + cnt_t'(hs);
    assign resp_ok   = sram_resp_valid && in_xfer && (resp_cnt < issued);
    assign resp_nxt  = resp_cnt + cnt_t'(resp_ok);
    assign accept    = (state == ARB_IDLE) && pick_any;
    assign resp_err  = sram_resp_valid && !resp_ok && !rst;

    always_comb begin
        state_n = state;
        unique case (state)
            ARB_IDLE: begin
                if (pick_any) state_n = ARB_BURST;
            end
            ARB_BURST: begin
                if (hs && last_beat) begin
                    if (resp_nxt == beats) state_n = ARB_DONE;
                    else                   state_n = ARB_WAIT_RESP;
                end
            end
            ARB_WAIT_RESP: begin
                if (resp_nxt == beats) state_n = ARB_DONE;
            end
            ARB_DONE: begin
                state_n = ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        xbar_valid  = 1'b0;
        xbar_write  = 1'b0;
        xbar_addr   = '0;
        xbar_last   = 1'b0;
        done        = '0;
        busy        = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (!rst) req_ready = pick_grant;
            end
            ARB_BURST: begin
                grant_valid = 1'b1;
                grant_id    = owner;
                busy        = 1'b1;
                xbar_valid  = 1'b1;
                xbar_write  = desc_q.write;
                xbar_addr   = desc_q.addr + ADDR_W'(beat_cnt);
                xbar_last   = last_beat;
            end
            ARB_WAIT_RESP: begin
                grant_valid = 1'b1;
                grant_id    = owner;
                busy        = 1'b1;
            end
            ARB_DONE: begin
                grant_valid = 1'b1;
                grant_id    = owner;
                busy        = 1'b1;
                done[owner] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            desc_q   <= '0;
            beat_cnt <= '0;
            resp_cnt <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                owner    <= pick_idx;
                desc_q   <= desc_in;
                beat_cnt <= '0;
                resp_cnt <= '0;
                if (pick_idx == IDW'(NUM_REQ - 1)) rr_ptr <= '0;
                else                               rr_ptr <= pick_idx + IDW'(1);
            end else begin
                if (hs) beat_cnt <= beat_cnt + cnt_t'(1);
                resp_cnt <= resp_nxt;
            end
        end
    end

endmodule

// File: tb/tb_scpad_xbar_arbiter.sv
// Scoreboard bench for scpad_xbar_arbiter: a transaction-level model
// predicts grants, beats, responses and done pulses cycle by cycle.
module tb_scpad_xbar_arbiter;

    localparam int N   = 4;
    localparam int AW  = 12;
    localparam int LW  = 5;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_ready;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;
    logic            xbar_valid;
    logic            xbar_ready;
    logic            xbar_write;
    logic [AW-1:0]   xbar_addr;
    logic            xbar_last;
    logic            sram_resp_valid;
    logic [N-1:0]    done;
    logic            resp_err;
    logic            busy;

    always #5 clk = ~clk;

    scpad_xbar_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .req_ready       (req_ready),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id),
        .xbar_valid      (xbar_valid),
        .xbar_ready      (xbar_ready),
        .xbar_write      (xbar_write),
        .xbar_addr       (xbar_addr),
        .xbar_last       (xbar_last),
        .sram_resp_valid (sram_resp_valid),
        .done            (done),
        .resp_err        (resp_err),
        .busy            (busy)
    );

    typedef struct {
        int addr;
        bit last;
    } beat_t;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    beat_t beat_q[$];
    int    resp_due[$];
    int    grant_log[$];
    int    addr_log[$];

    // Model: phase 0 = port free, 1 = burst owned, 2 = done cycle.
    int   m_phase = 0;
    int   m_rr = 0;
    int   m_id = 0;
    int   m_beats = 0;
    int   m_issued = 0;
    int   m_counted = 0;
    int   m_delay = 1;
    bit   m_write = 1'b0;
    int   ready_mode = 0;
    bit   spur = 1'b0;
    int   acc_cyc = 0;
    int   done_cyc = -1;
    int   hs_cnt = 0;
    int   err_cnt = 0;
    logic [N-1:0] pend_clear = '0;
    logic [N-1:0] owner_busy = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int win;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_done;
        bit exp_xv;
        bit exp_err;
        int base;
        if (rst) begin
            check("reset_outputs",
                  int'({req_ready, grant_valid, grant_id, xbar_valid,
                        xbar_write, xbar_addr, xbar_last, done,
                        resp_err, busy}), 0);
            m_phase = 0;
            m_rr = 0;
            beat_q.delete();
            resp_due.delete();
            pend_clear = '0;
            owner_busy = '0;
        end else begin
            for (int k = 0; k < N; k++)
                if (req_ready[k]) grant_log.push_back(k);
            if (xbar_valid && xbar_ready) begin
                hs_cnt++;
                addr_log.push_back(int'(xbar_addr));
            end
            if (resp_err) err_cnt++;
            if (done != 0) done_cyc = cyc;

            win = -1;
            if (m_phase == 0)
                for (int k = 0; k < N; k++)
                    if (win < 0 && req_valid[(m_rr + k) % N])
                        win = (m_rr + k) % N;
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;
            check("req_ready", int'(req_ready), int'(exp_ready));
            check("busy", int'(busy), int'(m_phase != 0));
            check("grant", int'(grant_valid) * 4 + int'(grant_id),
                  (m_phase != 0) ? 4 + m_id : 0);

            exp_xv = (m_phase == 1) && (beat_q.size() > 0);
            check("xbar_valid", int'(xbar_valid), int'(exp_xv));
            if (exp_xv && xbar_valid) begin
                check("xbar_addr", int'(xbar_addr), beat_q[0].addr);
                check("xbar_last", int'(xbar_last), int'(beat_q[0].last));
                check("xbar_write", int'(xbar_write), int'(m_write));
            end
            if (exp_xv && xbar_ready) begin
                void'(beat_q.pop_front());
                m_issued++;
                resp_due.push_back(cyc + m_delay);
            end

            exp_err = 1'b0;
            if (sram_resp_valid) begin
                if (m_phase == 1 && m_counted < m_issued) m_counted++;
                else exp_err = 1'b1;
            end
            check("resp_err", int'(resp_err), int'(exp_err));

            exp_done = '0;
            if (m_phase == 2) exp_done[m_id] = 1'b1;
            check("done", int'(done), int'(exp_done));

            if (m_phase == 2) begin
                m_phase = 0;
                owner_busy[m_id] = 1'b0;
            end else if (m_phase == 1 && m_counted == m_beats) begin
                m_phase = 2;
            end else if (win >= 0) begin
                m_phase   = 1;
                m_id      = win;
                m_rr      = (win + 1) % N;
                m_issued  = 0;
                m_counted = 0;
                m_beats   = int'(req_len[win*LW +: LW]) + 1;
                m_write   = req_write[win];
                base      = int'(req_addr[win*AW +: AW]);
                for (int i = 0; i < m_beats; i++)
                    beat_q.push_back('{addr: (base + i) % 4096,
                                       last: (i == m_beats - 1)});
                pend_clear[win] = 1'b1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid  = req_valid & ~pend_clear;
        pend_clear = '0;
        case (ready_mode)
            0:       xbar_ready = 1'b1;
            1:       xbar_ready = (cyc % 3 == 0);
            default: xbar_ready = 1'($urandom_range(0, 1));
        endcase
        sram_resp_valid = spur;
        if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
            void'(resp_due.pop_front());
            sram_resp_valid = 1'b1;
        end
    endtask

    task automatic post(input int id, input bit wr, input int addr,
                        input int len);
        req_valid[id]          = 1'b1;
        req_write[id]          = wr;
        req_addr[id*AW +: AW]  = AW'(addr);
        req_len[id*LW +: LW]   = LW'(len);
        owner_busy[id]         = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((req_valid != 0 || m_phase != 0 || owner_busy != 0)
               && n < 2000) begin
            tick();
            n++;
        end
        check({name, "_drain"}, int'(n < 2000), 1);
        tick();
        tick();
    endtask

    task automatic pulse_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int exp_g[5];
        int exp_a[4];
        rst             = 1'b1;
        req_valid       = '0;
        req_write       = '0;
        req_addr        = '0;
        req_len         = '0;
        xbar_ready      = 1'b1;
        sram_resp_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single 4-beat write from requester 1
        post(1, 1'b1, 'h010, 3);
        wait_idle("single");
        check("single_latency", done_cyc - acc_cyc, 6);
        check("single_err", err_cnt, 0);

        // All four requesters, one-beat bursts, pointer from zero
        pulse_reset();
        tick();
        grant_log.delete();
        for (int i = 0; i < N; i++) post(i, i[0], 'h100 * i, 0);
        n = 0;
        while (owner_busy[0] && n < 200) begin
            tick();
            n++;
        end
        check("rr_wait", int'(n < 200), 1);
        post(0, 1'b0, 'h3A0, 0);
        wait_idle("rr");
        exp_g = '{0, 1, 2, 3, 0};
        check("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("rr_order", grant_log[i], exp_g[i]);

        // Stalled crossbar, 3-beat read
        ready_mode = 1;
        hs_cnt = 0;
        post(2, 1'b0, 'h100, 2);
        wait_idle("stall");
        check("stall_hs", hs_cnt, 3);
        ready_mode = 0;

        // Address wrap across the top of the scratchpad
        addr_log.delete();
        post(3, 1'b1, 'hFFE, 3);
        wait_idle("wrap");
        exp_a = '{'hFFE, 'hFFF, 'h000, 'h001};
        check("wrap_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check("wrap_addr", addr_log[i], exp_a[i]);

        // Slow SRAM, then a stray response while idle
        m_delay = 5;
        post(0, 1'b0, 'h200, 3);
        wait_idle("slow");
        check("slow_latency", done_cyc - acc_cyc, 10);
        m_delay = 1;
        err_cnt = 0;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        tick();
        check("spur_err", err_cnt, 1);

        // Longest burst
        post(1, 1'b1, 'h7F0, 31);
        wait_idle("maxlen");
        check("maxlen_latency", done_cyc - acc_cyc, 34);

        // Reset on beat 2 of 4, then priority restarts at 0
        done_cyc = -1;
        post(1, 1'b1, 'h040, 3);
        n = 0;
        while (!(m_phase == 1 && m_issued == 2) && n < 100) begin
            tick();
            n++;
        end
        check("rst_reach", int'(n < 100), 1);
        pulse_reset();
        tick();
        tick();
        check("rst_no_done", done_cyc, -1);
        grant_log.delete();
        post(1, 1'b0, 'h050, 0);
        post(3, 1'b0, 'h060, 0);
        wait_idle("post_rst");
        check("post_rst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

        // Random traffic
        ready_mode = 2;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                int id;
                id = $urandom_range(0, N - 1);
                if (!owner_busy[id])
                    post(id, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 4095), $urandom_range(0, 7));
            end
            if (m_phase == 0) m_delay = $urandom_range(1, 4);
            tick();
        end
        wait_idle("random");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
